// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the hardwired R-type sequencer.
// Optional MUL/DIV support is enabled by defining RTYPE_SEQ_MULDIV_EN.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T4W   = 4'd6,
        ST_T5    = 4'd7,
        ST_T6    = 4'd8,
        ST_FAULT = 4'd15
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_SHRA = 5'b11101;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    // MUL/DIV are only legal when the HI/LO write-back path is built.
    function automatic logic is_legal_rtype(input logic [4:0] opcode);
        logic ok;
        ok = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_AND, OP_OR, OP_SHRA: ok = 1'b1;
`ifdef RTYPE_SEQ_MULDIV_EN
            OP_MUL, OP_DIV: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rtype_decode.sv
// Combinational opcode decode: legality, HI/LO class and ALU select.
// MUL/DIV recognised only when RTYPE_SEQ_MULDIV_EN is defined.
module rtype_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [4:0]      opcode,
    output logic            legal,
    output logic            muldiv,
    output logic [OP_W-1:0] op_sel
);

    // Pure lookup, no state.
    always_comb begin
        legal  = is_legal_rtype(opcode);
`ifdef RTYPE_SEQ_MULDIV_EN
        muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
`else
        muldiv = 1'b0;
`endif
        op_sel = {{(OP_W-5){1'b0}}, opcode};
    end

endmodule

// File: rtl/rtype_sequencer.sv
// Moore control-step FSM for three-operand ALU instructions (fetch + execute).
// Define RTYPE_SEQ_MULDIV_EN to add MUL/DIV with LO/HI write-back in T5/T6.
module rtype_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W  = 6,
    parameter int SEL_W = 4
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             run,
    input  logic [31:0]      IR,
    input  logic             finished,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             RFout,
    output logic             RFin,
    output logic             RYin,
    output logic             RZin,
    output logic             RZLOout,
    output logic             RZHIout,
    output logic             RLOin,
    output logic             RHIin,
    output logic [SEL_W-1:0] RFSelect,
    output logic [OP_W-1:0]  opSelect,
    output logic             start,
    output logic             fault,
    output logic [3:0]       step
);

    state_t state_q;
    state_t state_d;

    logic [4:0]      opcode;
    logic [SEL_W-1:0] ra;
    logic [SEL_W-1:0] rb;
    logic [SEL_W-1:0] rc;
    logic            dec_legal;
    logic            dec_muldiv;
    logic [OP_W-1:0] dec_op;
    logic            unused_ir;

    assign opcode    = IR[OPC_HI:OPC_LO];
    assign ra        = SEL_W'(IR[RA_HI:RA_LO]);
    assign rb        = SEL_W'(IR[RB_HI:RB_LO]);
    assign rc        = SEL_W'(IR[RC_HI:RC_LO]);
    assign unused_ir = ^IR[RC_LO-1:0];
    assign step      = state_q;

`ifndef RTYPE_SEQ_MULDIV_EN
    logic unused_muldiv;
    assign unused_muldiv = dec_muldiv;
`endif

    rtype_decode #(
        .OP_W (OP_W)
    ) u_decode (
        .opcode (opcode),
        .legal  (dec_legal),
        .muldiv (dec_muldiv),
        .op_sel (dec_op)
    );

    // State register; clear drops straight to IDLE without finishing.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode; everything defaults to 0.
    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        RFout    = 1'b0;
        RFin     = 1'b0;
        RYin     = 1'b0;
        RZin     = 1'b0;
        RZLOout  = 1'b0;
        RZHIout  = 1'b0;
        RLOin    = 1'b0;
        RHIin    = 1'b0;
        RFSelect = '0;
        opSelect = '0;
        start    = 1'b0;
        fault    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_T0;
            end
            ST_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                RZin    = 1'b1;
                state_d = ST_T1;
            end
            ST_T1: begin
                RZLOout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = ST_T2;
            end
            ST_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = ST_T3;
            end
            ST_T3: begin
                if (dec_legal) begin
                    RFSelect = rb;
                    RFout    = 1'b1;
                    RYin     = 1'b1;
                    state_d  = ST_T4;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            ST_T4, ST_T4W: begin
                RFSelect = rc;
                RFout    = 1'b1;
                opSelect = dec_op;
                RZin     = 1'b1;
                start    = (state_q == ST_T4);
                state_d  = finished ? ST_T5 : ST_T4W;
            end
            ST_T5: begin
                RZLOout = 1'b1;
`ifdef RTYPE_SEQ_MULDIV_EN
                if (dec_muldiv) begin
                    RLOin   = 1'b1;
                    state_d = ST_T6;
                end else begin
                    RFSelect = ra;
                    RFin     = 1'b1;
                    state_d  = run ? ST_T0 : ST_IDLE;
                end
`else
                RFSelect = ra;
                RFin     = 1'b1;
                state_d  = run ? ST_T0 : ST_IDLE;
`endif
            end
`ifdef RTYPE_SEQ_MULDIV_EN
            ST_T6: begin
                RZHIout = 1'b1;
                RHIin   = 1'b1;
                state_d = run ? ST_T0 : ST_IDLE;
            end
`endif
            ST_FAULT: begin
                fault   = 1'b1;
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

endmodule

// File: tb/tb_rtype_sequencer.sv
// Randomised self-checking bench for rtype_sequencer.
// Follows RTYPE_SEQ_MULDIV_EN so expectations match the build.
module tb_rtype_sequencer;

    logic        Clock;
    logic        clear;
    logic        run;
    logic [31:0] IR;
    logic        finished;
    logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic        RFout, RFin, RYin, RZin, RZLOout, RZHIout, RLOin, RHIin;
    logic [3:0]  RFSelect;
    logic [5:0]  opSelect;
    logic        start;
    logic        fault;
    logic [3:0]  step;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef RTYPE_SEQ_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic [4:0] base_ops [7] = '{5'b00011, 5'b00100, 5'b00101, 5'b00111,
                                 5'b01010, 5'b01011, 5'b11101};

    rtype_sequencer dut (
        .Clock    (Clock),
        .clear    (clear),
        .run      (run),
        .IR       (IR),
        .finished (finished),
        .PCout    (PCout),
        .MARin    (MARin),
        .IncPC    (IncPC),
        .PCin     (PCin),
        .Read     (Read),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .IRin     (IRin),
        .RFout    (RFout),
        .RFin     (RFin),
        .RYin     (RYin),
        .RZin     (RZin),
        .RZLOout  (RZLOout),
        .RZHIout  (RZHIout),
        .RLOin    (RLOin),
        .RHIin    (RHIin),
        .RFSelect (RFSelect),
        .opSelect (opSelect),
        .start    (start),
        .fault    (fault),
        .step     (step)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_md(input logic [4:0] op);
        return (op == 5'b01110) || (op == 5'b01111);
    endfunction

    function automatic bit legal(input logic [4:0] op);
        foreach (base_ops[k]) if (base_ops[k] == op) return 1'b1;
        return MD_EN && is_md(op);
    endfunction

    // Control bundle order: PCout MARin IncPC PCin Read MDRin MDRout IRin
    // RFout RFin RYin RZin RZLOout RZHIout RLOin RHIin start fault
    function automatic logic [17:0] exp_ctrl(input int st,
                                             input logic [31:0] ir);
        logic [17:0] v;
        bit lg, md;
        v  = '0;
        lg = legal(ir[31:27]);
        md = lg && MD_EN && is_md(ir[31:27]);
        case (st)
            1: v = 18'b111_0000_0000_1000_000;
            2: v = 18'b000_1110_0000_0100_000;
            default: v = '0;
        endcase
        case (st)
            1: v = 18'b1110_0000_0001_0000_00;
            2: v = 18'b0001_1100_0000_1000_00;
            3: v = 18'b0000_0011_0000_0000_00;
            4: v = lg ? 18'b0000_0000_1010_0000_00 : '0;
            5: v = 18'b0000_0000_1001_0000_10;
            6: v = 18'b0000_0000_1001_0000_00;
            7: v = md ? 18'b0000_0000_0000_1010_00
                      : 18'b0000_0000_0100_1000_00;
            8: v = 18'b0000_0000_0000_0101_00;
            15: v = 18'b0000_0000_0000_0000_01;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] exp_sel(input int st,
                                           input logic [31:0] ir);
        bit md;
        md = MD_EN && is_md(ir[31:27]);
        if (st == 4 && legal(ir[31:27])) return ir[22:19];
        if (st == 5 || st == 6) return ir[18:15];
        if (st == 7 && !md) return ir[26:23];
        return 4'd0;
    endfunction

    task automatic check_cycle(input int st, input logic [31:0] ir);
        logic [17:0] got;
        got = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
               RFout, RFin, RYin, RZin, RZLOout, RZHIout, RLOin, RHIin,
               start, fault};
        chk("step", 32'(step), 32'(st));
        chk("ctrl", 32'(got), 32'(exp_ctrl(st, ir)));
        chk("rfsel", 32'(RFSelect), 32'(exp_sel(st, ir)));
        chk("opsel", 32'(opSelect),
            (st == 5 || st == 6) ? 32'(ir[31:27]) : 32'd0);
    endtask

    // Runs one instruction from T0; leaves the DUT in T0 on return.
    task automatic do_instr(input logic [4:0] op, input int d,
                            input bit drop, input int abort);
        logic [31:0] ir;
        int q[$];
        bit lg, md, stopped;
        ir = {op, 27'($urandom)};
        lg = legal(op);
        md = lg && MD_EN && is_md(op);
        q = '{1, 2, 3, 4};
        stopped = 1'b0;
        if (!lg) begin
            repeat (12) q.push_back(15);
        end else begin
            q.push_back(5);
            repeat (d) q.push_back(6);
            q.push_back(7);
            if (md) q.push_back(8);
        end
        IR = $urandom;
        for (int i = 0; i < q.size(); i++) begin
            check_cycle(q[i], (i < 3) ? IR : ir);
            if (i == abort) begin
                stopped = 1'b1;
                break;
            end
            if (i == 2) IR = ir;
            finished = (i >= 4 + d) ? 1'b1 :
                       (i < 4) ? 1'($urandom) : 1'b0;
            if (drop && i >= 4) run = 1'b0;
            @(posedge Clock);
            #1;
        end
        if (!lg || stopped) begin
            clear = 1'b0;
            #1;
            check_cycle(0, ir);
            #1;
            clear = 1'b1;
            run = 1'b1;
            @(posedge Clock);
            #1;
        end else if (drop) begin
            check_cycle(0, ir);
            run = 1'b1;
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin
        clear = 1'b0;
        run = 1'b0;
        finished = 1'b0;
        IR = '0;
        repeat (2) @(posedge Clock);
        #1;
        check_cycle(0, IR);
        clear = 1'b1;
        @(posedge Clock);
        #1;
        check_cycle(0, IR);
        run = 1'b1;
        @(posedge Clock);
        #1;

        do_instr(5'b11101, 0, 1'b0, -1);
        do_instr(5'b00011, 2, 1'b0, -1);
        do_instr(5'b11111, 0, 1'b0, -1);
        do_instr(5'b01110, 1, 1'b0, -1);
        do_instr(5'b01111, 0, 1'b0, -1);
        do_instr(5'b00100, 1, 1'b1, -1);
        do_instr(5'b00011, 3, 1'b0, 6);
        do_instr(5'b01110, 0, 1'b1, -1);

        for (int n = 0; n < 60; n++) begin
            logic [4:0] op;
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) op = base_ops[$urandom_range(0, 6)];
            else if (r < 8) op = (r == 6) ? 5'b01110 : 5'b01111;
            else op = 5'($urandom);
            do_instr(op, $urandom_range(0, 3),
                     $urandom_range(0, 7) == 0,
                     ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
